dff_checker: RTL and testbench
==============================

DFF_CHECKER -- requirements
Module: dff_checker

Interface
REQ-001 SHALL have parameter LATENCY, default 1: cycles from d_out sampled to matching q_in (1..4).
REQ-002 SHALL have parameter CNT_W, default 8: error-counter width.
REQ-003 SHALL have parameter SETTLE, default 2: cycles ignored after arming (0..15).
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 en  input  1  check-window enable; 1 = arm/check, 0 = stop.
REQ-007 d_in  input  1  data bit driven into the flip-flop under test this cycle.
REQ-008 dut_rst_in  input  1  reset bit driven into the flip-flop under test this cycle (active-high, forces expected 0).
REQ-009 q_in  input  1  flip-flop-under-test output.
REQ-010 busy  output  1  high in SETTLE or CHECK.
REQ-011 err  output  1  sticky mismatch flag.
REQ-012 err_cnt  output  CNT_W  mismatch count, saturating.
REQ-013 chk_cnt  output  16  compared-cycle count, saturating at 16'hFFFF.
REQ-014 done  output  1  high in DONE; results stable.
REQ-015 first_err_cyc  output  16  chk_cnt value at first mismatch (macro-dependent).

Function
REQ-016 Expected bit each cycle SHALL be exp = dut_rst_in ? 0 : d_in, delayed through a LATENCY-deep shift pipeline; tail compared with q_in.
REQ-017 Pipeline SHALL shift every cycle regardless of state; reset clears all stages to 0.
REQ-018 FSM states SHALL be IDLE, SETTLE, CHECK, DONE.
REQ-019 IDLE: en=1 -> SETTLE, clearing err, err_cnt, chk_cnt, first_err_cyc.
REQ-020 SETTLE: count SETTLE cycles, no comparisons; -> CHECK after SETTLE cycles (SETTLE=0: directly CHECK next cycle); en=0 -> IDLE.
REQ-021 CHECK: each cycle with en=1 SHALL compare; chk_cnt +1; on q_in != tail, err=1 and err_cnt +1.
REQ-022 CHECK: en=0 -> DONE; no comparison that cycle.
REQ-023 DONE: outputs held; en=1 -> SETTLE with counters cleared as REQ-019.
REQ-024 err_cnt SHALL saturate at all-ones; err stays 1; no wrap.
REQ-025 chk_cnt SHALL saturate at 16'hFFFF; comparisons continue.
REQ-026 Results SHALL update one cycle after the compared q_in sample (registered outputs).
REQ-027 dut_rst_in and d_in changing the same cycle: dut_rst_in wins (expected 0).

Reset
REQ-028 reset=1 at a rising edge SHALL force IDLE; busy=0, done=0, err=0, err_cnt=0, chk_cnt=0, first_err_cyc=0, pipeline 0.
REQ-029 reset mid-SETTLE or mid-CHECK SHALL abort the window and discard all results; en sampled again from next cycle.
REQ-030 reset SHALL take priority over en.

Configuration
REQ-031 With DFF_CHECKER_FIRST_ERR_EN defined: first_err_cyc SHALL capture chk_cnt (pre-increment) at the first mismatch of a window and hold until cleared.
REQ-032 Without DFF_CHECKER_FIRST_ERR_EN: first_err_cyc SHALL be constant 0 and its capture logic absent.

Verification
REQ-033 reset=1 2 cycles, then en=0 -> busy=0, done=0, err=0, err_cnt=0, chk_cnt=0.
REQ-034 Ideal 1-cycle DFF model on q_in, dut_rst_in=0, d toggling, en=1 for 50 cycles, SETTLE=2 -> done=1, err=0, chk_cnt=48.
REQ-035 Same, q_in forced 1 during 3 cycles where expected 0 -> err=1, err_cnt=3, first_err_cyc = chk_cnt of first forced cycle (macro on), 0 (macro off).
REQ-036 dut_rst_in=1, d_in=1 for 10 cycles, model q=0 -> err=0; model ignoring reset (q=1) -> err_cnt=10 (less any cycles in SETTLE).
REQ-037 CNT_W=4, q_in inverted for 40 checked cycles -> err_cnt=4'hF, err=1.
REQ-038 reset pulsed at CHECK cycle 20 with err=1 -> next cycle IDLE, err=0, err_cnt=0; re-arm gives a clean window.

Source files
------------

// File: rtl/dff_checker.sv
// Self-checking monitor for a single flip-flop under test: predicts q from d/rst and counts mismatches.
// Optional first-mismatch capture is enabled by defining DFF_CHECKER_FIRST_ERR_EN.
module dff_checker #(
    parameter int LATENCY = 1,
    parameter int CNT_W   = 8,
    parameter int SETTLE  = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             d_in,
    input  logic             dut_rst_in,
    input  logic             q_in,
    output logic             busy,
    output logic             err,
    output logic [CNT_W-1:0] err_cnt,
    output logic [15:0]      chk_cnt,
    output logic             done,
    output logic [15:0]      first_err_cyc
);

    typedef enum logic [1:0] {IDLE, SETTLE_ST, CHECK, DONE} state_t;

    // The arming cycle counts as the first ignored cycle, so SETTLE of 0 or 1 goes straight to CHECK.
    localparam bit         SKIP_SETTLE = (SETTLE <= 1);
    localparam logic [3:0] SETTLE_LD   = SKIP_SETTLE ? 4'd0 : 4'(SETTLE - 1);

    state_t             state_q, state_d;
    logic [3:0]         settle_cnt_q, settle_cnt_d;
    logic [LATENCY-1:0] pipe_q, pipe_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
    logic [15:0]        chk_cnt_q, chk_cnt_d;
    logic               clear;
    logic               compare;
    logic               mismatch;

    always_comb begin
        pipe_d[0] = dut_rst_in ? 1'b0 : d_in;
        for (int i = 1; i < LATENCY; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        clear        = 1'b0;
        compare      = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (en) begin
                    clear = 1'b1;
                    if (SKIP_SETTLE) begin
                        state_d = CHECK;
                    end else begin
                        state_d      = SETTLE_ST;
                        settle_cnt_d = SETTLE_LD;
                    end
                end
            end
            SETTLE_ST: begin
                if (!en) begin
                    state_d = IDLE;
                end else if (settle_cnt_q <= 4'd1) begin
                    state_d = CHECK;
                end else begin
                    settle_cnt_d = settle_cnt_q - 4'd1;
                end
            end
            CHECK: begin
                if (!en) begin
                    state_d = DONE;
                end else begin
                    compare = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        mismatch = compare && (q_in != pipe_q[LATENCY-1]);
    end

    always_comb begin
        err_d     = err_q;
        err_cnt_d = err_cnt_q;
        chk_cnt_d = chk_cnt_q;
        if (clear) begin
            err_d     = 1'b0;
            err_cnt_d = '0;
            chk_cnt_d = '0;
        end
        if (compare) begin
            chk_cnt_d = (&chk_cnt_q) ? chk_cnt_q : chk_cnt_q + 16'd1;
        end
        if (mismatch) begin
            err_d     = 1'b1;
            err_cnt_d = (&err_cnt_q) ? err_cnt_q : err_cnt_q + 1'b1;
        end
        busy_d = (state_d == SETTLE_ST) || (state_d == CHECK);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        pipe_q <= reset ? '0 : pipe_d;
        if (reset) begin
            state_q      <= IDLE;
            settle_cnt_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            err_cnt_q    <= '0;
            chk_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            err_cnt_q    <= err_cnt_d;
            chk_cnt_q    <= chk_cnt_d;
        end
    end

`ifdef DFF_CHECKER_FIRST_ERR_EN
    logic [15:0] first_err_q, first_err_d;

    always_comb begin
        first_err_d = first_err_q;
        if (clear) begin
            first_err_d = '0;
        end
        if (mismatch && !err_q) begin
            first_err_d = chk_cnt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            first_err_q <= '0;
        end else begin
            first_err_q <= first_err_d;
        end
    end

    assign first_err_cyc = first_err_q;
`else
    assign first_err_cyc = '0;
`endif

    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;
    assign err_cnt = err_cnt_q;
    assign chk_cnt = chk_cnt_q;

endmodule

// File: tb/tb_dff_checker.sv
// Randomized scoreboard bench for dff_checker; window results are predicted from a cycle history model.
module tb_dff_checker;

    localparam int LAT        = 1;
    localparam int CW         = 4;
    localparam int ST         = 2;
    localparam int ST_EFF     = (ST < 1) ? 1 : ST;
    localparam int ECNT_MAX   = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          en = 1'b0;
    logic          d_in = 1'b0;
    logic          dut_rst_in = 1'b0;
    logic          q_in = 1'b0;
    logic          busy, err, done;
    logic [CW-1:0] err_cnt;
    logic [15:0]   chk_cnt, first_err_cyc;

    always #5 clk = ~clk;

    dff_checker #(.LATENCY(LAT), .CNT_W(CW), .SETTLE(ST)) dut (
        .clk(clk), .reset(reset), .en(en), .d_in(d_in), .dut_rst_in(dut_rst_in),
        .q_in(q_in), .busy(busy), .err(err), .err_cnt(err_cnt), .chk_cnt(chk_cnt),
        .done(done), .first_err_cyc(first_err_cyc)
    );

    typedef struct {
        int err;
        int ecnt;
        int ccnt;
        int first;
    } res_t;

    res_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    int   hist[0:8191];   // expected bit presented to the flop at each edge
    int   dhist[0:8191];  // raw d bit at each edge, ignoring the flop reset

    task automatic chk(input string name, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic int past(input int c);
        return (c < 0) ? 0 : hist[c];
    endfunction

    function automatic int dpast(input int c);
        return (c < 0) ? 0 : dhist[c];
    endfunction

    task automatic step(input bit r, input bit e, input bit d, input bit ri, input bit q);
        reset = r; en = e; d_in = d; dut_rst_in = ri; q_in = q;
        hist[cyc]  = r ? 0 : (ri ? 0 : int'(d));
        dhist[cyc] = r ? 0 : int'(d);
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            step(0, 0, 1'($urandom_range(1)), 0, 1'(past(cyc - LAT)));
        end
    endtask

    // dmode: 0 toggle, 1 random, 2 constant 1
    // rmode: 0 never, 1 always, 2 random
    // qmode: 0 ideal, 1 three forced-1 faults, 2 inverted, 3 ignores flop reset, 4 random flips
    task automatic window(input int n, input int dmode, input int rmode, input int qmode,
                          input int abort_at);
        int   checked = 0;
        int   mism    = 0;
        int   first   = -1;
        int   forced  = 0;
        int   last_f  = -100;
        bit   d, ri, q, ideal;
        res_t r;
        for (int j = 0; j < n; j++) begin
            case (dmode)
                0:       d = 1'(j & 1);
                1:       d = 1'($urandom_range(1));
                default: d = 1'b1;
            endcase
            case (rmode)
                0:       ri = 1'b0;
                1:       ri = 1'b1;
                default: ri = ($urandom_range(3) == 0);
            endcase
            ideal = 1'(past(cyc - LAT));
            case (qmode)
                1: begin
                    q = ideal;
                    if (j >= 10 && forced < 3 && !ideal && (j - last_f) >= 5) begin
                        q = 1'b1; forced++; last_f = j;
                    end
                end
                2:       q = !ideal;
                3:       q = 1'(dpast(cyc - LAT));
                4:       q = ideal ^ ($urandom_range(7) == 0);
                default: q = ideal;
            endcase
            if (j == abort_at) begin
                chk("pre_abort_err", int'(err), 1);
                step(1, 1, d, ri, q);
                chk("abort_busy", int'(busy), 0);
                chk("abort_done", int'(done), 0);
                chk("abort_err", int'(err), 0);
                chk("abort_err_cnt", int'(err_cnt), 0);
                chk("abort_chk_cnt", int'(chk_cnt), 0);
                chk("abort_first", int'(first_err_cyc), 0);
                return;
            end
            if (j >= ST_EFF) begin
                if (q != ideal) begin
                    mism++;
                    if (first < 0) first = checked;
                end
                checked++;
            end
            step(0, 1, d, ri, q);
        end
        step(0, 0, 1'($urandom_range(1)), 0, 1'(past(cyc - LAT)));
        r.err  = (mism > 0) ? 1 : 0;
        r.ecnt = (mism > ECNT_MAX) ? ECNT_MAX : mism;
        r.ccnt = (checked > 65535) ? 65535 : checked;
`ifdef DFF_CHECKER_FIRST_ERR_EN
        r.first = (first < 0) ? 0 : first;
`else
        r.first = 0;
`endif
        exp_q.push_back(r);
    endtask

    initial begin : monitor
        logic prev_done = 1'b0;
        res_t r;
        forever begin
            @(negedge clk);
            if (done && !prev_done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    r = exp_q.pop_front();
                    chk("err", int'(err), r.err);
                    chk("err_cnt", int'(err_cnt), r.ecnt);
                    chk("chk_cnt", int'(chk_cnt), r.ccnt);
                    chk("first_err_cyc", int'(first_err_cyc), r.first);
                    chk("busy_in_done", int'(busy), 0);
                end
            end
            prev_done = done;
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_err_cnt", int'(err_cnt), 0);
        chk("rst_chk_cnt", int'(chk_cnt), 0);
        chk("rst_first", int'(first_err_cyc), 0);

        window(50, 0, 0, 0, -1);
        idle(2);
        window(50, 0, 0, 1, -1);
        idle(1);
        window(10, 2, 1, 0, -1);
        window(10, 2, 1, 3, -1);
        idle(3);
        window(40 + ST_EFF, 1, 2, 2, -1);
        idle(2);
        window(60, 1, 0, 2, ST_EFF + 20);
        window(30, 1, 2, 0, -1);
        idle(1);
        for (int k = 0; k < 10; k++) begin
            window($urandom_range(60, 2), 1, 2, ($urandom_range(3) == 0) ? 3 : 4, -1);
            idle($urandom_range(3));
        end
        idle(4);
        chk("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
